// File: rtl/multiply_iter.sv
// Iterative multiplier: retires STEP bits of the sign-extended multiplier per cycle,
// with independent operand signedness, a kill input for flushes and a busy flag.
module multiply_iter #(
    parameter int unsigned A_W  = 32,
    parameter int unsigned B_W  = 32,
    parameter int unsigned STEP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic               stb,
    input  logic               kill,
    output logic [A_W+B_W-1:0] o,
    output logic               ack,
    output logic               busy
);

    localparam int unsigned O_W   = A_W + B_W;
    localparam int unsigned N     = (B_W + STEP) / STEP;
    localparam int unsigned BX_W  = N * STEP;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [O_W-1:0]           mcand_q, mcand_d;
    logic [BX_W-1:0]          mplier_q, mplier_d;
    logic [O_W-1:0]           acc_q, acc_d;
    logic [O_W-1:0]           o_q, o_d;
    logic                     ack_q, ack_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic                     last;
    logic signed [STEP:0]     digit_s;
    logic signed [O_W-1:0]    digit_ext;
    logic signed [O_W-1:0]    mcand_s;
    logic [O_W-1:0]           partial;
    logic [O_W-1:0]           acc_sum;
    logic signed [A_W:0]      a_ext;
    logic signed [B_W:0]      b_ext;

    // Digit datapath: the multiplier is sign-extended to N*STEP bits, so only the
    // final digit is signed and a narrower last digit needs no special handling.
    always_comb begin
        a_ext     = $signed({a[A_W-1] & a_signed, a});
        b_ext     = $signed({b[B_W-1] & b_signed, b});
        accept    = (state_q != ST_RUN) && stb && !kill;
        last      = (cnt_q == CNT_W'(N - 1));
        digit_s   = $signed({last & mplier_q[STEP-1], mplier_q[STEP-1:0]});
        digit_ext = O_W'(digit_s);
        mcand_s   = $signed(mcand_q);
        partial   = O_W'(mcand_s * digit_ext);
        acc_sum   = acc_q + partial;
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        o_d      = o_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = O_W'(a_ext);
                    mplier_d = BX_W'(b_ext);
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << STEP;
                    mplier_d = mplier_q >> STEP;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last) begin
                        o_d     = acc_sum;
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            o_q      <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            o_q      <= o_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign o    = o_q;
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule
